// File: rtl/bisr_job_scheduler.sv
// Job scheduler in front of the BISR systolic array: runs the power-on and periodic
// stop-the-world self-test, hands matmul jobs to the array one at a time, and stops
// for good on an unrepairable fault map or an unresponsive array.

`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module bisr_job_scheduler #(
    parameter int unsigned ROWS           = `ROWS,
    parameter int unsigned COLS           = `COLS,
    parameter int unsigned STW_INTERVAL   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            job_req_valid,
    output logic                            job_req_ready,
    input  logic [7:0]                      job_tag,
    output logic                            job_done,
    output logic [7:0]                      done_tag,
    output logic                            start_fsm,
    output logic                            start_matmul,
    input  logic                            fsm_rdy,
    input  logic                            STW_complete,
    input  logic [ROWS*COLS-1:0]            STW_result_mat,
    output logic [ROWS*COLS-1:0]            fault_map,
    output logic [$clog2(ROWS*COLS+1)-1:0]  fault_cnt,
    output logic                            unrepairable,
    output logic                            timeout_err,
    output logic [15:0]                     jobs_done_cnt
);

    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [15:0]    IvlMax = 16'(STW_INTERVAL);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [WdW-1:0] WdOne  = WdW'(1);

    typedef enum logic [3:0] {
        StReset, StStwLaunch, StStwWait, StRdyWait, StIdle,
        StIssue, StBusyWait, StDoneWait, StFault, StErr
    } state_e;

    state_e          state_q;
    logic [15:0]     ivl_q;
    logic [WdW-1:0]  wd_q;
    logic [7:0]      tag_q;
    logic            job_req_ready_q, job_done_q, start_fsm_q, start_matmul_q;
    logic [7:0]      done_tag_q;
    logic [N-1:0]    fault_map_q;
    logic [CntW-1:0] fault_cnt_q;
    logic            unrepairable_q, timeout_err_q;
    logic [15:0]     jobs_done_cnt_q;

    logic [CntW-1:0] mat_cnt;
    logic            mat_bad;
    int unsigned     col_cnt;
    logic            wd_expire;

    // Popcount of the incoming STW map and the per-column "two or more faults" check.
    always_comb begin
        mat_cnt = '0;
        mat_bad = 1'b0;
        col_cnt = 0;
        for (int c = 0; c < int'(COLS); c++) begin
            col_cnt = 0;
            for (int r = 0; r < int'(ROWS); r++) begin
                col_cnt = col_cnt + 32'(STW_result_mat[c*ROWS + r]);
            end
            if (col_cnt >= 2) mat_bad = 1'b1;
            mat_cnt = mat_cnt + CntW'(col_cnt);
        end
    end

    assign wd_expire = (wd_q == WdLast);

    // Scheduler FSM; every output is a register set on the transition into its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StReset;
            ivl_q           <= '0;
            wd_q            <= '0;
            tag_q           <= '0;
            job_req_ready_q <= 1'b0;
            job_done_q      <= 1'b0;
            start_fsm_q     <= 1'b0;
            start_matmul_q  <= 1'b0;
            done_tag_q      <= '0;
            fault_map_q     <= '0;
            fault_cnt_q     <= '0;
            unrepairable_q  <= 1'b0;
            timeout_err_q   <= 1'b0;
            jobs_done_cnt_q <= '0;
        end else begin
            job_req_ready_q <= 1'b0;
            job_done_q      <= 1'b0;
            start_fsm_q     <= 1'b0;
            start_matmul_q  <= 1'b0;
            wd_q            <= '0;
            unique case (state_q)
                StReset: begin
                    state_q     <= StStwLaunch;
                    start_fsm_q <= 1'b1;
                end
                StStwLaunch: state_q <= StStwWait;
                StStwWait: begin
                    if (STW_complete) begin
                        fault_map_q <= STW_result_mat;
                        fault_cnt_q <= mat_cnt;
                        ivl_q       <= '0;
                        if (mat_bad) begin
                            state_q        <= StFault;
                            unrepairable_q <= 1'b1;
                        end else begin
                            state_q <= StRdyWait;
                        end
                    end else if (wd_expire) begin
                        state_q       <= StErr;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WdOne;
                    end
                end
                StRdyWait: begin
                    if (fsm_rdy) begin
                        state_q         <= StIdle;
                        job_req_ready_q <= (ivl_q != IvlMax);
                    end else if (wd_expire) begin
                        state_q       <= StErr;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WdOne;
                    end
                end
                StIdle: begin
                    // A due self-test wins over a pending job; ready stays low meanwhile.
                    if (ivl_q == IvlMax) begin
                        state_q     <= StStwLaunch;
                        start_fsm_q <= 1'b1;
                    end else if (job_req_valid && job_req_ready_q) begin
                        state_q        <= StIssue;
                        tag_q          <= job_tag;
                        start_matmul_q <= 1'b1;
                    end else begin
                        job_req_ready_q <= 1'b1;
                    end
                end
                StIssue: state_q <= StBusyWait;
                StBusyWait: begin
                    if (!fsm_rdy) begin
                        state_q <= StDoneWait;
                    end else if (wd_expire) begin
                        state_q       <= StErr;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WdOne;
                    end
                end
                StDoneWait: begin
                    if (fsm_rdy) begin
                        state_q         <= StIdle;
                        job_done_q      <= 1'b1;
                        done_tag_q      <= tag_q;
                        jobs_done_cnt_q <= jobs_done_cnt_q + 16'd1;
                        ivl_q           <= ivl_q + 16'd1;
                        job_req_ready_q <= ((ivl_q + 16'd1) != IvlMax);
                    end else if (wd_expire) begin
                        state_q       <= StErr;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WdOne;
                    end
                end
                StFault: state_q <= StFault;
                StErr:   state_q <= StErr;
                default: state_q <= StErr;
            endcase
        end
    end

    assign job_req_ready = job_req_ready_q;
    assign job_done      = job_done_q;
    assign done_tag      = done_tag_q;
    assign start_fsm     = start_fsm_q;
    assign start_matmul  = start_matmul_q;
    assign fault_map     = fault_map_q;
    assign fault_cnt     = fault_cnt_q;
    assign unrepairable  = unrepairable_q;
    assign timeout_err   = timeout_err_q;
    assign jobs_done_cnt = jobs_done_cnt_q;

endmodule

// File: tb/tb_bisr_job_scheduler.sv
// Randomized scoreboard bench for bisr_job_scheduler: a behavioural array model answers
// start pulses, a requester issues jobs, and a monitor checks every job_done in order.

module tb_bisr_job_scheduler;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int N        = ROWS * COLS;
    localparam int INTERVAL = 2;
    localparam int TIMEOUT  = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_req_valid, job_req_ready;
    logic [7:0]   job_tag, done_tag;
    logic         job_done, start_fsm, start_matmul, fsm_rdy, STW_complete;
    logic [N-1:0] STW_result_mat, fault_map;
    logic [4:0]   fault_cnt;
    logic         unrepairable, timeout_err;
    logic [15:0]  jobs_done_cnt;

    always #5 clk = ~clk;

    bisr_job_scheduler #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .STW_INTERVAL   (INTERVAL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_req_valid  (job_req_valid),
        .job_req_ready  (job_req_ready),
        .job_tag        (job_tag),
        .job_done       (job_done),
        .done_tag       (done_tag),
        .start_fsm      (start_fsm),
        .start_matmul   (start_matmul),
        .fsm_rdy        (fsm_rdy),
        .STW_complete   (STW_complete),
        .STW_result_mat (STW_result_mat),
        .fault_map      (fault_map),
        .fault_cnt      (fault_cnt),
        .unrepairable   (unrepairable),
        .timeout_err    (timeout_err),
        .jobs_done_cnt  (jobs_done_cnt)
    );

    typedef struct { logic [7:0] tag; logic [15:0] cnt; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int cyc = 0, rise_cyc = -10;
    int mdl_jobs = 0, since_stw = 0, stw_count = 0, env_lat = 5;
    bit hang = 0, rand_map = 0;
    logic [N-1:0] stw_mat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit col_bad(input logic [N-1:0] m);
        int n;
        for (int c = 0; c < COLS; c++) begin
            n = 0;
            for (int r = 0; r < ROWS; r++) n += int'(m[c*ROWS + r]);
            if (n >= 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Random repairable map: at most one faulty PE per column.
    function automatic logic [N-1:0] gen_map();
        logic [N-1:0] m = '0;
        for (int c = 0; c < COLS; c++)
            if ($urandom_range(0, 1) == 1) m[c*ROWS + int'($urandom_range(0, ROWS-1))] = 1'b1;
        return m;
    endfunction

    // Behavioural array: answers start_fsm with a self-test result and start_matmul with
    // a busy window of env_lat cycles.
    initial begin
        int stw_t = 0, rdy_t = 0, mm_t = 0, busy_t = 0;
        bit fired = 0, chk = 0;
        logic [N-1:0] emap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stw_t = 0; rdy_t = 0; mm_t = 0; busy_t = 0; chk = 0; stw_count = 0;
                if (fired) STW_complete = 1'b0;
                fired = 0;
                fsm_rdy = 1'b0;
                continue;
            end
            if (fired) begin STW_complete = 1'b0; fired = 0; end
            if (chk) begin
                chk = 0;
                check("fault_map", 32'(fault_map), 32'(emap));
                check("fault_cnt", 32'(fault_cnt), 32'($countones(emap)));
                check("unrepairable", 32'(unrepairable), 32'(col_bad(emap)));
            end
            if (rdy_t > 0) begin rdy_t--; if (rdy_t == 0) fsm_rdy = 1'b1; end
            if (busy_t > 0) begin
                busy_t--;
                if (busy_t == 0) begin fsm_rdy = 1'b1; rise_cyc = cyc; end
            end
            if (mm_t > 0) begin
                mm_t--;
                if (mm_t == 0) begin fsm_rdy = 1'b0; busy_t = env_lat; end
            end
            if (stw_t > 0) begin
                stw_t--;
                if (stw_t == 0) begin
                    STW_complete = 1'b1; STW_result_mat = emap; fired = 1; chk = 1;
                    since_stw = 0;
                    if (!col_bad(emap)) rdy_t = 2;
                end
            end
            if (start_fsm) begin
                fsm_rdy = 1'b0; stw_t = 10; stw_count++;
                emap = rand_map ? gen_map() : stw_mat;
            end
            if (start_matmul && !hang) mm_t = 3;
        end
    end

    // Monitor: every job_done must match the oldest outstanding job.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && job_done) begin
                if (sb.size() == 0) begin
                    check("job_done_unexpected", 32'(job_done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_tag", 32'(done_tag), 32'(e.tag));
                    check("jobs_done_cnt", 32'(jobs_done_cnt), 32'(e.cnt));
                    check("done_latency", 32'(cyc), 32'(rise_cyc + 1));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(job_req_ready), 0);
        check("rst_done", 32'(job_done), 0);
        check("rst_done_tag", 32'(done_tag), 0);
        check("rst_start_fsm", 32'(start_fsm), 0);
        check("rst_start_matmul", 32'(start_matmul), 0);
        check("rst_fault_map", 32'(fault_map), 0);
        check("rst_fault_cnt", 32'(fault_cnt), 0);
        check("rst_unrepairable", 32'(unrepairable), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_jobs_done_cnt", 32'(jobs_done_cnt), 0);
        sb.delete();
        mdl_jobs = 0; since_stw = 0; job_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("start_fsm_pre", 32'(start_fsm), 0);
        @(negedge clk);
        check("start_fsm_rise", 32'(start_fsm), 1);
        @(negedge clk);
        check("start_fsm_pulse", 32'(start_fsm), 0);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!job_req_ready && t < 200) begin @(negedge clk); t++; end
        check("ready_bound", 32'(job_req_ready), 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin @(negedge clk); t++; end
        check("drain_bound", 32'(sb.size()), 0);
    endtask

    task automatic send_job(input logic [7:0] tag, input int lat);
        int t = 0;
        env_lat = lat;
        job_req_valid = 1'b1;
        job_tag = tag;
        while (!job_req_ready && t < 300) begin @(negedge clk); t++; end
        check("accept_bound", 32'(job_req_ready), 1);
        if (!job_req_ready) begin job_req_valid = 1'b0; return; end
        check("accept_interval", 32'(since_stw < INTERVAL), 1);
        since_stw++;
        mdl_jobs++;
        sb.push_back('{tag: tag, cnt: 16'(mdl_jobs)});
        @(negedge clk);
        job_req_valid = 1'b0;
        check("start_matmul", 32'(start_matmul), 1);
        check("ready_drop", 32'(job_req_ready), 0);
    endtask

    initial begin
        int t, bad;
        job_req_valid = 1'b0; job_tag = '0; fsm_rdy = 1'b0;
        STW_complete = 1'b0; STW_result_mat = '0;

        // Clean boot.
        do_reset();
        wait_ready();
        check("boot_fault_cnt", 32'(fault_cnt), 0);
        check("boot_jobs_cnt", 32'(jobs_done_cnt), 0);

        // A self-test result outside STW_WAIT is ignored.
        @(negedge clk);
        STW_result_mat = '1; STW_complete = 1'b1;
        @(negedge clk);
        STW_complete = 1'b0;
        @(negedge clk);
        check("stray_fault_map", 32'(fault_map), 0);
        check("stray_fault_cnt", 32'(fault_cnt), 0);
        check("stray_ready", 32'(job_req_ready), 1);

        // Single job.
        send_job(8'h5A, 40);
        wait_drain();
        check("single_jobs_cnt", 32'(jobs_done_cnt), 1);

        // Random jobs with periodic retests; the first few offered back-to-back.
        rand_map = 1;
        for (int i = 0; i < 14; i++) begin
            if (i >= 3) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_job(8'($urandom), int'($urandom_range(1, 40)));
        end
        wait_drain();
        wait_ready();
        check("stw_count", 32'(stw_count), 32'(1 + mdl_jobs / INTERVAL));
        check("rand_jobs_cnt", 32'(jobs_done_cnt), 32'(mdl_jobs));
        rand_map = 0;

        // Repairable: one fault in each of columns 0 and 1.
        stw_mat = 16'h0042;
        do_reset();
        wait_ready();
        check("rep_fault_cnt", 32'(fault_cnt), 2);
        check("rep_unrepairable", 32'(unrepairable), 0);
        send_job(8'hC3, 5);
        wait_drain();

        // Unrepairable: two faults in column 0.
        stw_mat = 16'h0003;
        do_reset();
        t = 0;
        while (!unrepairable && t < 100) begin @(negedge clk); t++; end
        check("unrep_flag", 32'(unrepairable), 1);
        job_req_valid = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (job_req_ready || start_fsm || start_matmul) bad++;
        end
        job_req_valid = 1'b0;
        check("unrep_stuck", 32'(bad), 0);
        check("unrep_fault_cnt", 32'(fault_cnt), 2);

        // Watchdog: the array never drops fsm_rdy after start_matmul.
        stw_mat = '0;
        hang = 1;
        do_reset();
        wait_ready();
        send_job(8'h77, 5);
        t = 0;
        while (!timeout_err && t < 200) begin @(negedge clk); t++; end
        check("timeout_latency", 32'(t), 32'(TIMEOUT + 1));
        check("timeout_ready", 32'(job_req_ready), 0);
        check("timeout_no_done", 32'(sb.size()), 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (start_fsm || start_matmul || job_done) bad++;
        end
        check("timeout_quiet", 32'(bad), 0);
        hang = 0;

        // Reset while a job sits in DONE_WAIT: the job is lost.
        do_reset();
        wait_ready();
        send_job(8'h33, 40);
        repeat (10) @(negedge clk);
        do_reset();
        wait_ready();
        repeat (60) @(negedge clk);
        check("midrst_jobs_cnt", 32'(jobs_done_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
